// File: rtl/bsg_lru_pseudo_tree_state.sv
// Per-set pseudo-LRU tree store. Each access rewrites the root-to-leaf path so
// every node on it points away from the touched way; reads are registered.
module bsg_lru_pseudo_tree_state #(
    parameter int sets_p = 64,
    parameter int ways_p = 16,
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1,
    localparam int lg_ways_lp = $clog2(ways_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_v_i,
    input  logic [lg_sets_lp-1:0] rd_set_i,
    output logic                  lru_v_o,
    output logic [ways_p-2:0]     lru_o,
    input  logic                  up_v_i,
    input  logic [lg_sets_lp-1:0] up_set_i,
    input  logic [lg_ways_lp-1:0] up_way_i
);

    localparam int tree_w = ways_p - 1;

    // Walk root to leaf using the way bits MSB first; each visited node gets
    // the complement of the branch taken.
    function automatic logic [tree_w-1:0] touch_tree(
        input logic [tree_w-1:0]     tree,
        input logic [lg_ways_lp-1:0] way
    );
        logic [tree_w-1:0]     res;
        logic [lg_ways_lp-1:0] node;
        logic                  b;
        res  = tree;
        node = '0;
        for (int k = 0; k < lg_ways_lp; k++) begin
            b         = way[lg_ways_lp-1-k];
            res[node] = ~b;
            node      = (node << 1) + lg_ways_lp'(1) + lg_ways_lp'(b);
        end
        return res;
    endfunction

    logic [tree_w-1:0] tree_r [sets_p];
    logic [tree_w-1:0] lru_p1;
    logic              vld_p1;

    logic [tree_w-1:0] rd_raw;
    logic [tree_w-1:0] up_raw;
    logic [tree_w-1:0] up_touched;
    logic [tree_w-1:0] rd_next;
    logic              rd_hit;
    logic              up_hit;
    logic              bypass;

    // Out-of-range indices match no set: reads see zero, updates write nothing.
    always_comb begin
        rd_raw = '0;
        rd_hit = 1'b0;
        up_raw = '0;
        up_hit = 1'b0;
        for (int s = 0; s < sets_p; s++) begin
            if (rd_set_i == lg_sets_lp'(s)) begin
                rd_raw = tree_r[s];
                rd_hit = 1'b1;
            end
            if (up_set_i == lg_sets_lp'(s)) begin
                up_raw = tree_r[s];
                up_hit = 1'b1;
            end
        end
        up_touched = touch_tree(up_raw, up_way_i);
        bypass     = up_v_i & up_hit & rd_hit & (up_set_i == rd_set_i);
        rd_next    = bypass ? up_touched : rd_raw;
    end

    // ---- stage p1: registered read result and tree update ----
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < sets_p; s++) begin
                tree_r[s] <= '0;
            end
            lru_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_v_i;
            if (rd_v_i) begin
                lru_p1 <= rd_next;
            end
            for (int s = 0; s < sets_p; s++) begin
                if (up_v_i && (up_set_i == lg_sets_lp'(s))) begin
                    tree_r[s] <= up_touched;
                end
            end
        end
    end

    assign lru_o   = lru_p1;
    assign lru_v_o = vld_p1;

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_state.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-node reference model of the pseudo-LRU trees.
module tb_bsg_lru_pseudo_tree_state;

    localparam int SETS = 4;
    localparam int WAYS = 16;
    localparam int NODES = WAYS - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_v;
    logic [1:0]  rd_set;
    logic        lru_v;
    logic [14:0] lru;
    logic        up_v;
    logic [1:0]  up_set;
    logic [3:0]  up_way;

    int vectors = 0;
    int errors  = 0;

    bit          model [SETS][NODES];
    logic        exp_vld;
    logic [14:0] exp_lru;

    always #5 clk = ~clk;

    bsg_lru_pseudo_tree_state #(.sets_p(SETS), .ways_p(WAYS)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .rd_v_i  (rd_v),
        .rd_set_i(rd_set),
        .lru_v_o (lru_v),
        .lru_o   (lru),
        .up_v_i  (up_v),
        .up_set_i(up_set),
        .up_way_i(up_way)
    );

    function automatic logic [14:0] model_tree(input int s);
        logic [14:0] t;
        for (int n = 0; n < NODES; n++) t[n] = model[s][n];
        return t;
    endfunction

    // Follow node bits from the root down to a leaf; leaf index minus NODES is the way.
    function automatic int victim(input logic [14:0] t);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) n = 2 * n + 1 + int'(t[n[3:0]]);
        return n - NODES;
    endfunction

    task automatic model_touch(input int s, input int w);
        int n;
        int b;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            b = (w >> (3 - k)) & 1;
            model[s][n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < NODES; n++) model[s][n] = 1'b0;
    endtask

    // Drive one cycle, advance the model, and check both outputs after the edge.
    task automatic op(input bit rst, input bit rv, input int rs,
                      input bit uv, input int us, input int uw);
        reset  = rst;
        rd_v   = rv;
        rd_set = rs[1:0];
        up_v   = uv;
        up_set = us[1:0];
        up_way = uw[3:0];
        if (rst) begin
            model_clear();
            exp_vld = 1'b0;
            exp_lru = '0;
        end else begin
            if (uv) model_touch(us, uw);
            exp_vld = rv;
            if (rv) exp_lru = model_tree(rs);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (lru_v !== exp_vld) begin
            errors++;
            $display("FAIL model_vld: got %b expected %b (t=%0t)", lru_v, exp_vld, $time);
        end
        vectors++;
        if (lru !== exp_lru) begin
            errors++;
            $display("FAIL model_lru: got %h expected %h (t=%0t)", lru, exp_lru, $time);
        end
        reset = 1'b0;
        rd_v  = 1'b0;
        up_v  = 1'b0;
    endtask

    task automatic test_reset();
        op(1, 0, 0, 0, 0, 0);
        op(1, 0, 0, 0, 0, 0);
        vectors++;
        if (lru_v !== 1'b0 || lru !== 15'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b lru=%h expected v=0 lru=0000", lru_v, lru);
        end
        op(0, 1, 2, 0, 0, 0);
        vectors++;
        if (lru_v !== 1'b1 || lru !== 15'h0000) begin
            errors++;
            $display("FAIL reset_read: got v=%b lru=%h expected v=1 lru=0000", lru_v, lru);
        end
    endtask

    task automatic test_single_update();
        op(0, 0, 0, 1, 1, 0);
        op(0, 1, 1, 0, 0, 0);
        vectors++;
        if (lru !== 15'h008B) begin
            errors++;
            $display("FAIL touch_way0: got %h expected 008b", lru);
        end
        vectors++;
        if (victim(lru) != 8) begin
            errors++;
            $display("FAIL victim_after_way0: got %0d expected 8", victim(lru));
        end
        op(0, 1, 2, 0, 0, 0);
        vectors++;
        if (lru !== 15'h0000) begin
            errors++;
            $display("FAIL other_set_untouched: got %h expected 0000", lru);
        end
    endtask

    task automatic test_way15_then_way0();
        op(1, 0, 0, 0, 0, 0);
        op(0, 0, 0, 1, 0, 15);
        op(0, 1, 0, 0, 0, 0);
        vectors++;
        if (lru !== 15'h0000) begin
            errors++;
            $display("FAIL touch_way15: got %h expected 0000", lru);
        end
        op(0, 0, 0, 1, 0, 0);
        op(0, 1, 0, 0, 0, 0);
        vectors++;
        if (lru !== 15'h008B) begin
            errors++;
            $display("FAIL way15_then_way0: got %h expected 008b", lru);
        end
    endtask

    task automatic test_bypass();
        op(0, 0, 0, 1, 3, 1);
        op(0, 1, 3, 1, 3, 5);
        vectors++;
        if (lru !== 15'h0019) begin
            errors++;
            $display("FAIL bypass_same_set: got %h expected 0019", lru);
        end
        op(0, 1, 2, 1, 1, 9);
        vectors++;
        if (lru !== 15'h0000) begin
            errors++;
            $display("FAIL bypass_diff_set: got %h expected 0000", lru);
        end
    endtask

    task automatic test_round_robin();
        op(1, 0, 0, 0, 0, 0);
        for (int w = 0; w < WAYS; w++) begin
            op(0, 1, 0, 1, 0, w);
            vectors++;
            if (victim(lru) == w) begin
                errors++;
                $display("FAIL rr_victim_is_touched: got victim %0d, must differ from %0d", victim(lru), w);
            end
        end
        vectors++;
        if (victim(lru) != 0) begin
            errors++;
            $display("FAIL rr_final_victim: got %0d expected 0", victim(lru));
        end
    endtask

    task automatic test_random();
        op(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            op(0, $urandom_range(0, 1) == 1, $urandom_range(0, SETS - 1),
               $urandom_range(0, 2) != 0, $urandom_range(0, SETS - 1),
               $urandom_range(0, WAYS - 1));
        end
    endtask

    task automatic test_reset_midstream();
        for (int s = 0; s < SETS; s++) op(0, 0, 0, 1, s, $urandom_range(0, WAYS - 1));
        op(1, 1, 1, 1, 2, 3);
        vectors++;
        if (lru_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstream_vld: got %b expected 0", lru_v);
        end
        for (int s = 0; s < SETS; s++) begin
            op(0, 1, s, 0, 0, 0);
            vectors++;
            if (lru !== 15'h0000) begin
                errors++;
                $display("FAIL reset_midstream_set%0d: got %h expected 0000", s, lru);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_v    = 1'b0;
        rd_set  = '0;
        up_v    = 1'b0;
        up_set  = '0;
        up_way  = '0;
        exp_vld = 1'b0;
        exp_lru = '0;
        model_clear();
        test_reset();
        test_single_update();
        test_way15_then_way0();
        test_bypass();
        test_round_robin();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
